// File: rtl/mips_fetch_queue.sv
// MIPS instruction-fetch front end: credit-limited word fetch into a DEPTH-entry prefetch queue.
// Optional `HALT_STOP_EN: stop fetching once an instruction with opcode 6'b111111 is enqueued.
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_npc,
    output logic        fetch_stalled
);
    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   npc_q   [DEPTH];
    logic          halted;
    logic          credit_ok;
    logic          req_fire;
    logic          pop;
    logic          enq;

    // Queued plus in-flight fetches share one credit pool, so an enqueue can never overflow.
    assign credit_ok      = ({1'b0, count} + {1'b0, inflight}) < CAP;
    assign imem_req_valid = !rst && !redirect_valid && credit_ok && !halted;
    assign imem_req_addr  = fetch_pc;
    assign fetch_stalled  = !credit_ok || halted;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = (count != '0) && !redirect_valid;
    assign out_instr = instr_q[head];
    assign out_npc   = npc_q[head];
    assign pop       = out_valid && out_ready;
    assign enq       = imem_rsp_valid && (drop == '0) && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_valid) begin
            // A response landing in the redirect cycle is itself discarded, hence the minus one.
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= inflight - CW'(imem_rsp_valid);
            drop     <= inflight - CW'(imem_rsp_valid);
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd1;
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop != '0))
                drop <= drop - CW'(1);
            if (enq) begin
                tail   <= tail + AW'(1);
                rsp_pc <= rsp_pc + 32'd1;
            end
            if (pop)
                head <= head + AW'(1);
            count <= count + CW'(enq) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[tail] <= imem_rsp_data;
            npc_q[tail]   <= rsp_pc + 32'd1;
        end
    end

`ifdef HALT_STOP_EN
    always_ff @(posedge clk) begin
        if (rst || redirect_valid)
            halted <= 1'b0;
        else if (enq && (imem_rsp_data[31:26] == 6'b111111))
            halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: latency-configurable memory model, order scoreboard, directed vectors.
module tb_mips_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_npc;
    logic        fetch_stalled;

    always #5 clk = ~clk;

    mips_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_npc(out_npc), .fetch_stalled(fetch_stalled)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] instr; logic [31:0] npc; } exp_t;
    typedef struct packed {
        logic        ordy;
        logic        rv;
        logic [31:0] addr;
        logic        st;
        logic        ov;
        logic [31:0] npc;
    } vec_t;

    pend_t pend[$];
    exp_t  sb[$];
    exp_t  sb_e;
    vec_t  vt[11];
    int    ncyc    = 0;
    int    lat     = 1;
    int    pop_cnt = 0;
    int    checks  = 0;
    int    errors  = 0;
    int    pc0;
    bit    hlt_en  = 1'b0;

    function automatic logic [31:0] memf(logic [31:0] a);
        if (hlt_en && a == 32'd5)
            return 32'hFC00_0000;
        return 32'h1000_0000 + a;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    // Sampled mid-cycle: every handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            pop_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_pop instr=%h npc=%h expected=none", out_instr, out_npc);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_instr", out_instr, sb_e.instr);
                chk("sb_npc", out_npc, sb_e.npc);
            end
        end
        if (rst || redirect_valid)
            sb.delete();
        if (rst)
            pend.delete();
        else if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: ncyc + lat});
            sb.push_back('{instr: memf(imem_req_addr), npc: imem_req_addr + 32'd1});
        end
        if (!rst && pend.size() > 0 && pend[0].due <= ncyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        ncyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b0;
        tick();
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_stalled", fetch_stalled, 1'b0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        chk("redir_out_valid", out_valid, 1'b0);
        chk("redir_req_valid", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0};
        vt[1]  = '{1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 32'd0};
        vt[2]  = '{1'b0, 1'b1, 32'd2, 1'b0, 1'b1, 32'd1};
        vt[3]  = '{1'b0, 1'b1, 32'd3, 1'b0, 1'b1, 32'd1};
        vt[4]  = '{1'b0, 1'b0, 32'd4, 1'b1, 1'b1, 32'd1};
        vt[5]  = '{1'b0, 1'b0, 32'd4, 1'b1, 1'b1, 32'd1};
        vt[6]  = '{1'b0, 1'b0, 32'd4, 1'b1, 1'b1, 32'd1};
        vt[7]  = '{1'b1, 1'b0, 32'd4, 1'b1, 1'b1, 32'd1};
        vt[8]  = '{1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 32'd2};
        vt[9]  = '{1'b1, 1'b1, 32'd5, 1'b0, 1'b1, 32'd3};
        vt[10] = '{1'b1, 1'b1, 32'd6, 1'b0, 1'b1, 32'd4};

        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Streaming with single-cycle memory.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        #1;
        chk("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, 32'd0);
        tick();
        chk("lat_out_valid_early", out_valid, 1'b0);
        tick();
        chk("lat_out_valid", out_valid, 1'b1);
        chk("lat_out_instr", out_instr, 32'h1000_0000);
        chk("lat_out_npc", out_npc, 32'd1);
        pc0 = pop_cnt;
        repeat (10) tick();
        chk("steady_throughput", pop_cnt - pc0, 10);

        // Backpressure fills the credit pool, then drains one entry per cycle.
        do_reset();
        imem_req_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            out_ready = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d_req_valid", i), imem_req_valid, vt[i].rv);
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].addr);
            chk($sformatf("vec%0d_stalled", i), fetch_stalled, vt[i].st);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].ov);
            if (vt[i].ov)
                chk($sformatf("vec%0d_out_npc", i), out_npc, vt[i].npc);
            tick();
        end

        // Redirect with three fetches in flight and no response that cycle.
        do_reset();
        lat = 4;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (3) tick();
        imem_req_ready = 1'b0;
        redirect_to(32'h40);
        imem_req_ready = 1'b1;
        #1;
        chk("r3_req_valid", imem_req_valid, 1'b1);
        chk("r3_req_addr", imem_req_addr, 32'h40);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("r3_drain%0d_out_valid", i), out_valid, 1'b0);
        end
        tick();
        chk("r3_first_valid", out_valid, 1'b1);
        chk("r3_first_instr", out_instr, 32'h1000_0040);
        chk("r3_first_npc", out_npc, 32'h41);

        // Redirect coincident with a response and a would-be pop.
        do_reset();
        lat = 2;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (6) tick();
        redirect_to(32'h100);
        chk("rc_req_addr", imem_req_addr, 32'h100);
        chk("rc_out_valid0", out_valid, 1'b0);
        tick();
        chk("rc_out_valid1", out_valid, 1'b0);
        tick();
        chk("rc_out_valid2", out_valid, 1'b0);
        tick();
        chk("rc_first_valid", out_valid, 1'b1);
        chk("rc_first_instr", out_instr, 32'h1000_0100);
        chk("rc_first_npc", out_npc, 32'h101);

        // Halt opcode at address 5.
        do_reset();
        hlt_en = 1'b1;
        lat = 1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (7) tick();
`ifdef HALT_STOP_EN
        chk("halt_req_valid", imem_req_valid, 1'b0);
        chk("halt_stalled", fetch_stalled, 1'b1);
        repeat (3) tick();
        chk("halt_hold_req_valid", imem_req_valid, 1'b0);
        chk("halt_hold_stalled", fetch_stalled, 1'b1);
`else
        chk("nohalt_req_valid", imem_req_valid, 1'b1);
        chk("nohalt_req_addr", imem_req_addr, 32'd7);
        chk("nohalt_stalled", fetch_stalled, 1'b0);
        repeat (3) tick();
        chk("nohalt_later_addr", imem_req_addr, 32'd10);
`endif
        redirect_to(32'h0);
        chk("halt_resume_valid", imem_req_valid, 1'b1);
        chk("halt_resume_addr", imem_req_addr, 32'd0);
        chk("halt_resume_stalled", fetch_stalled, 1'b0);
        repeat (8) tick();
        hlt_en = 1'b0;

        // Fetch PC wraps at the top of the address space.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (3) tick();
        redirect_to(32'hFFFF_FFFF);
        chk("wrap_req_valid", imem_req_valid, 1'b1);
        chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFF);
        tick();
        chk("wrap_req_addr1", imem_req_addr, 32'h0);
        tick();
        chk("wrap_out_valid", out_valid, 1'b1);
        chk("wrap_out_instr", out_instr, 32'h0FFF_FFFF);
        chk("wrap_out_npc", out_npc, 32'h0);
        repeat (4) tick();

        do_reset();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
